// File: rtl/sobel_pkg.sv
// Shared Sobel types: stream packet, default frame geometry, post-processor states.
package sobel_pkg;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int BORDER_DEF = 2;

  // Stream beat exchanged between Sobel stages; only data[7:0] carries pixels here.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  slot;
    logic [1:0]  pad;
    logic        last;
    logic        valid;
  } PCIEPacket;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } post_state_t;

endpackage

// File: rtl/sobel_pix_counter.sv
// Column/row position tracker for one frame, with border and frame-end flags.
module sobel_pix_counter #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int BORDER = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic advance_i,   // a valid beat is consumed this cycle
  input  logic restart_i,   // upstream closed the frame early; go back to (0,0)
  output logic is_border_o, // current position lies in the masked border
  output logic is_end_o     // current position is the last pixel of the frame
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_B   = CW'(BORDER);
  localparam logic [RW-1:0] ROW_B   = RW'(BORDER);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign is_end_o    = (col_q == COL_MAX) && (row_q == ROW_MAX);
  assign is_border_o = (col_q < COL_B) || (row_q < ROW_B);

  // Next position: hold on bubbles, restart on frame end or early last, else raster step.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (advance_i) begin
      if (restart_i || is_end_o) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sobel_post_proc.sv
// Sobel output stage: border masking, optional binary threshold, last regeneration
// and frame-length checking over a fixed two-stage pipeline.
module sobel_post_proc
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int BORDER = BORDER_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  PCIEPacket  pcie_packet_in,
  input  logic       thresh_en,
  input  logic [7:0] thresh_val,
  output PCIEPacket  pcie_packet_out,
  output logic       frame_done,
  output logic       len_err
);

  post_state_t state_q;
  logic        th_en_q;
  logic [7:0]  th_val_q;

  logic        s1_valid_q, s1_mask_q, s1_end_q;
  logic [7:0]  s1_data_q;
  logic [7:0]  s2_data_d;
  PCIEPacket   out_q;
  logic        frame_done_q, len_err_q;

  logic in_valid, in_last, pos_border, pos_end, beat_end;

  assign in_valid = pcie_packet_in.valid;
  assign in_last  = pcie_packet_in.last;
  // Either the counted end or an upstream last closes the frame (only one close per beat).
  assign beat_end = pos_end || in_last;

  // Only the low pixel byte of the incoming beat is meaningful.
  logic unused_in_bits;
  assign unused_in_bits = ^{pcie_packet_in.data[31:8], pcie_packet_in.slot, pcie_packet_in.pad};

  sobel_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .BORDER(BORDER)
  ) u_pix_counter (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (in_valid),
    .restart_i  (in_last),
    .is_border_o(pos_border),
    .is_end_o   (pos_end)
  );

  // Frame FSM: threshold settings are captured only on the first beat of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      th_en_q  <= 1'b0;
      th_val_q <= 8'h00;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          th_en_q  <= thresh_en;
          th_val_q <= thresh_val;
          state_q  <= beat_end ? IDLE : ACTIVE;
        end
        ACTIVE: begin
          if (beat_end) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky length error: upstream last disagrees with the counted frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_err_q <= 1'b0;
    end else if (in_valid && (in_last != pos_end)) begin
      len_err_q <= 1'b1;
    end
  end

  // Stage 1: capture the beat with its position flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 8'h00;
      s1_mask_q  <= 1'b0;
      s1_end_q   <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_data_q  <= pcie_packet_in.data[7:0];
      s1_mask_q  <= pos_border;
      s1_end_q   <= in_valid && beat_end;
    end
  end

  // Pixel value: mask first, then threshold (strict greater-than) or pass-through.
  always_comb begin
    s2_data_d = s1_data_q;
    if (s1_mask_q) begin
      s2_data_d = 8'h00;
    end else if (th_en_q) begin
      s2_data_d = (s1_data_q > th_val_q) ? 8'hFF : 8'h00;
    end
  end

  // Stage 2: final registered beat and frame-done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_q        <= '0;
      out_q.valid  <= s1_valid_q;
      out_q.last   <= s1_valid_q && s1_end_q;
      out_q.data   <= {24'h0, (s1_valid_q ? s2_data_d : 8'h00)};
      frame_done_q <= s1_valid_q && s1_end_q;
    end
  end

  assign pcie_packet_out = out_q;
  assign frame_done      = frame_done_q;
  assign len_err         = len_err_q;

endmodule

// File: tb/tb_sobel_post_proc.sv
// Randomized scoreboard bench for sobel_post_proc on a 4x3 frame.
module tb_sobel_post_proc;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  PCIEPacket  pin, pout;
  logic       ten;
  logic [7:0] tval;
  logic       fd, lerr;

  always #5 clk = ~clk;

  sobel_post_proc #(.IMG_W(W), .IMG_H(H), .BORDER(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcie_packet_in (pin),
    .thresh_en      (ten),
    .thresh_val     (tval),
    .pcie_packet_out(pout),
    .frame_done     (fd),
    .len_err        (lerr)
  );

  typedef struct {
    logic [7:0] d;
    bit         last;
    int         cyc;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0, cyc = 0, n_in = 0, n_out = 0;

  // Reference model state: linear pixel index within the frame.
  bit         m_active = 0;
  int         m_pos = 0;
  bit         m_en = 0;
  logic [7:0] m_val = 8'h00;
  bit         m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected output of one accepted beat, computed from pixel index arithmetic.
  function automatic void model(input logic [7:0] mag, input bit last);
    int row, col;
    bit mask, pend, endb;
    exp_t e;
    if (!m_active) begin
      m_active = 1;
      m_pos    = 0;
      m_en     = ten;
      m_val    = tval;
    end
    row  = m_pos / W;
    col  = m_pos % W;
    mask = (row < 2) || (col < 2);
    e.d  = mask ? 8'h00 : (m_en ? ((mag > m_val) ? 8'hFF : 8'h00) : mag);
    pend = (m_pos == N - 1);
    endb = pend || last;
    if (last != pend) m_err = 1;
    if (endb) begin
      m_active = 0;
      m_pos    = 0;
    end else begin
      m_pos++;
    end
    e.last = endb;
    e.cyc  = cyc + 2;
    q.push_back(e);
    n_in++;
  endfunction

  task automatic idle();
    @(negedge clk);
    pin = '0;
  endtask

  task automatic beat(input logic [7:0] mag, input bit last, input bit bub);
    if (bub && $urandom_range(0, 1) == 1) idle();
    @(negedge clk);
    pin           = '0;
    pin.data      = $urandom();
    pin.data[7:0] = mag;
    pin.valid     = 1'b1;
    pin.last      = last;
    model(mag, last);
  endtask

  function automatic logic [7:0] pick(input int mode);
    logic [7:0] tbl [4];
    tbl[0] = 8'h80; tbl[1] = 8'h81; tbl[2] = 8'hFF; tbl[3] = 8'h7F;
    if (mode == 0) return 8'h40;
    if (mode == 1) return tbl[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  // n beats; last raised on beat last_at (0 = never); thresh_val switches to new_val at beat chg_at.
  task automatic frame(input int n, input int last_at, input bit bub, input int mode,
                       input int chg_at, input logic [7:0] new_val);
    for (int i = 1; i <= n; i++) begin
      if (i == chg_at) tval = new_val;
      beat(pick(mode), (i == last_at), bub);
    end
    idle();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    chk({tag, "_drain"}, q.size(), 0);
    chk({tag, "_len_err"}, {31'b0, lerr}, {31'b0, m_err});
  endtask

  // Monitor: pops the scoreboard for every output beat.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pout.valid) begin
        n_out++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with no expected beat", pout.data);
        end else begin
          e = q.pop_front();
          chk("data", pout.data, {24'h0, e.d});
          chk("last", {31'b0, pout.last}, {31'b0, e.last});
          chk("frame_done", {31'b0, fd}, {31'b0, e.last});
          chk("latency_cycle", cyc, e.cyc);
          chk("slot_pad", {26'b0, pout.slot, pout.pad}, 0);
        end
      end else begin
        chk("idle_frame_done", {31'b0, fd}, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    pin  = '0;
    ten  = 1'b0;
    tval = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'b0, pout.valid}, 0);
    chk("reset_frame_done", {31'b0, fd}, 0);
    chk("reset_len_err", {31'b0, lerr}, 0);
    rst = 1'b0;

    // Pass-through, constant 0x40.
    ten = 0;
    frame(N, N, 0, 0, 0, 8'h00);
    drain("passthru");

    // Threshold at 0x80 with boundary magnitudes.
    ten = 1; tval = 8'h80;
    frame(N, N, 0, 1, 0, 8'h00);
    drain("thresh");

    // Random settings and magnitudes with ~50% bubbles.
    for (int r = 0; r < 4; r++) begin
      ten  = 1'($urandom_range(0, 1));
      tval = 8'($urandom_range(0, 255));
      frame(N, N, 1, 2, 0, 8'h00);
      drain("bubbles");
    end

    // Early last on beat 7, then a clean frame.
    ten = 0;
    frame(7, 7, 0, 2, 0, 8'h00);
    drain("early_last");
    frame(N, N, 1, 2, 0, 8'h00);
    drain("after_early");

    // Threshold change mid-frame applies only to the following frame.
    ten = 1; tval = 8'h10;
    frame(N, N, 0, 2, 6, 8'hF0);
    drain("thresh_hold");
    frame(N, N, 0, 2, 0, 8'h00);
    drain("thresh_new");

    // Reset on beat 5 of a frame.
    ten = 0;
    for (int i = 1; i <= 4; i++) beat(pick(2), 0, 0);
    @(negedge clk);
    rst       = 1'b1;
    pin.valid = 1'b1;
    pin.data  = 32'h55;
    @(posedge clk);
    #2;
    chk("rst_out_valid", {31'b0, pout.valid}, 0);
    chk("rst_frame_done", {31'b0, fd}, 0);
    chk("rst_len_err", {31'b0, lerr}, 0);
    n_in -= q.size();
    q.delete();
    m_active = 0; m_pos = 0; m_err = 0; m_en = 0; m_val = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    pin = '0;
    frame(N, N, 0, 2, 0, 8'h00);
    drain("after_reset");

    // Missing last at the counted end.
    frame(N, 0, 1, 2, 0, 8'h00);
    drain("missing_last");
    frame(N, N, 1, 2, 0, 8'h00);
    drain("final");

    chk("beat_count", n_out, n_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
